// File: rtl/key_in_pkg.sv
// Register map and bit positions shared by the key-in FIFO peripheral.
package key_in_pkg;

   typedef enum logic [1:0] {
      ADDR_DATA     = 2'd0,
      ADDR_STATUS   = 2'd1,
      ADDR_IRQ_MASK = 2'd2,
      ADDR_RSVD     = 2'd3
   } reg_addr_e;

   localparam int DATA_VALID_BIT = 8;
   localparam int ST_COUNT_W     = 5;
   localparam int ST_EMPTY_BIT   = 8;
   localparam int ST_FULL_BIT    = 9;
   localparam int ST_OVF_BIT     = 10;
   localparam int MASK_NE_BIT    = 0;
   localparam int MASK_OVF_BIT   = 1;

endpackage

// File: rtl/key_in_fifo_mem.sv
// Key-code FIFO storage with wrapping pointers and an occupancy count.
// Callers only assert push when not full (or popping) and pop when not empty.
module key_in_fifo_mem #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           wr_data,
   output logic [WIDTH-1:0]           rd_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       empty,
   output logic                       full
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W:0]   count_q;

   assign count   = count_q;
   assign empty   = (count_q == '0);
   assign full    = (count_q == (PTR_W+1)'(DEPTH));
   assign rd_data = mem_q[rd_ptr];

   // Storage is data only; it needs no reset because count gates visibility.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/lab8_soc_key_in_fifo.sv
// Avalon-MM key-code FIFO: fabric pushes key codes, the CPU pops them via DATA.
// Optional repeat filter enabled by defining KEY_IN_DEDUP_EN.
module lab8_soc_key_in_fifo
   import key_in_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [1:0]           address,
   input  logic                 chipselect,
   input  logic                 read_n,
   input  logic                 write_n,
   input  logic [31:0]          writedata,
   output logic [31:0]          readdata,
   input  logic [WIDTH-1:0]     in_code,
   input  logic                 in_valid,
   output logic                 irq
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] head_code;
   logic [CNT_W-1:0] count;
   logic             empty;
   logic             full;
   logic             rd_sel;
   logic             wr_sel;
   logic             pop;
   logic             want;
   logic             push;
   logic             ovf_set;
   logic             ovf_clr;
   logic             overflow;
   logic [1:0]       irq_mask;
   logic             unused_wdata;

   assign rd_sel = chipselect & ~read_n;
   assign wr_sel = chipselect & ~write_n;
   assign pop    = rd_sel & (address == ADDR_DATA) & ~empty;

`ifdef KEY_IN_DEDUP_EN
   logic [WIDTH-1:0] last_code;
   logic             last_vld;

   // A release code (0) always passes and re-arms the filter.
   assign want = in_valid &
                 ~(last_vld & (in_code == last_code) & (in_code != '0));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_code <= '0;
         last_vld  <= 1'b0;
      end else if (push) begin
         last_code <= in_code;
         last_vld  <= (in_code != '0);
      end
   end
`else
   assign want = in_valid;
`endif

   // A pop in the same cycle frees the slot, so a full FIFO can still accept.
   assign push    = want & (~full | pop);
   assign ovf_set = want & full & ~pop;
   assign ovf_clr = wr_sel & (address == ADDR_STATUS) & writedata[ST_OVF_BIT];

   key_in_fifo_mem #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
   ) u_mem (
      .clk     (clk),
      .reset   (reset),
      .push    (push),
      .pop     (pop),
      .wr_data (in_code),
      .rd_data (head_code),
      .count   (count),
      .empty   (empty),
      .full    (full)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow <= 1'b0;
         irq_mask <= 2'b00;
         irq      <= 1'b0;
      end else begin
         overflow <= ovf_set | (overflow & ~ovf_clr);
         if (wr_sel && (address == ADDR_IRQ_MASK)) begin
            irq_mask <= writedata[MASK_OVF_BIT:MASK_NE_BIT];
         end
         irq <= (irq_mask[MASK_NE_BIT] & ~empty) | (irq_mask[MASK_OVF_BIT] & overflow);
      end
   end

   always_comb begin
      readdata = '0;
      case (address)
         ADDR_DATA: begin
            if (!empty) begin
               readdata[DATA_VALID_BIT] = 1'b1;
               readdata[7:0]            = 8'(head_code);
            end
         end
         ADDR_STATUS: begin
            readdata[ST_COUNT_W-1:0] = ST_COUNT_W'(count);
            readdata[ST_EMPTY_BIT]   = empty;
            readdata[ST_FULL_BIT]    = full;
            readdata[ST_OVF_BIT]     = overflow;
         end
         ADDR_IRQ_MASK: begin
            readdata[MASK_OVF_BIT:MASK_NE_BIT] = irq_mask;
         end
         ADDR_RSVD: begin
            readdata = '0;
         end
         default: begin
            readdata = '0;
         end
      endcase
   end

   assign unused_wdata = ^{writedata[31:ST_OVF_BIT+1], writedata[ST_OVF_BIT-1:MASK_OVF_BIT+1]};

endmodule
